inmf_dram_arb: RTL
==================

Name: inmf_dram_arb

Overview:
- Arbiter and sequencer for one 256x32 simple-dual-port inmf_dram instance (port A write-only, port B read-only, 1-cycle read latency, single common clock).
- Shares port A among NW write requesters and port B among NR read requesters, each with independent round-robin arbitration.
- Contains a clear sequencer that sweeps the whole memory to INIT_VAL.
- Prevents same-address write/read collisions, which are undefined across the two ports.

Parameters:
- NW, 2: number of write requesters (1..8).
- NR, 4: number of read requesters (1..8).
- AW, 8: address width; memory depth is 2**AW.
- DW, 32: data width.
- INIT_VAL, 32'h0: value written by the clear sweep.

Ports:
- clk  in  1  single clock for the arbiter and both DRAM ports.
- rst_n  in  1  asynchronous active-low reset.
- init_start  in  1  pulse that starts the clear sweep; ignored while init_busy.
- init_busy  out  1  high while the sweep runs.
- init_done  out  1  one-cycle pulse after the last sweep write.
- wr_req  in  NW  per-requester write request; held until acked.
- wr_addr  in  NW*AW  packed write addresses; requester i occupies bits [i*AW +: AW].
- wr_data  in  NW*DW  packed write data.
- wr_ack  out  NW  one-hot, combinational; the write is performed in the same cycle.
- rd_req  in  NR  per-requester read request; held until acked.
- rd_addr  in  NR*AW  packed read addresses.
- rd_ack  out  NR  one-hot, combinational.
- rd_rvalid  out  NR  one-hot, registered; asserted 1 cycle after the matching rd_ack.
- rd_rdata  out  DW  read data, valid when any rd_rvalid bit is set.
- ena  out  1  DRAM port A enable.
- wea  out  1  DRAM port A write enable.
- addra  out  AW  DRAM port A address.
- dina  out  DW  DRAM port A write data.
- enb  out  1  DRAM port B enable.
- addrb  out  AW  DRAM port B address.
- doutb  in  DW  DRAM port B read data.

Behaviour:
- Reset values: init_busy=0, init_done=0, rd_rvalid=0, both round-robin pointers=0, sweep counter=0, FSM=IDLE.
- Reset values, combinational outputs: wr_ack, rd_ack, ena, wea, enb are 0 whenever no request is granted. addra, addrb and dina are don't-care when their enable is low; drive them to 0.
- Request handshake:
  - A requester holds req, addr and data stable until it sees ack.
  - ack is a single-cycle event per transaction.
  - If req stays high after ack, that is a new request.
- Round-robin arbitration, per port:
  - The grant is the first requesting index at or after the pointer, with wrap-around.
  - After a grant, the pointer moves to (granted index + 1) mod N.
  - With no request, the pointer holds.
- Write port mapping: on a write grant, ena=wea=1, addra=granted wr_addr, dina=granted wr_data.
- Read port mapping: on a read grant, enb=1 and addrb=granted rd_addr.
- Read return timing:
  - A 1-bit-per-requester valid shift register (a registered copy of rd_ack) drives rd_rvalid.
  - rd_rdata=doutb.
  - Back-to-back reads are allowed every cycle.
- FSM state IDLE: normal arbitration. init_start moves the FSM to CLEAR with the counter at 0.
- FSM state CLEAR:
  - Port A writes INIT_VAL at the counter address (ena=wea=1); the counter increments each cycle.
  - All wr_ack and rd_ack are forced to 0; requests stay pending.
  - Reads already in flight still return their rd_rvalid.
  - When counter=2**AW-1, that write occurs, then the FSM goes to IDLE with init_done=1 for one cycle.
  - Sweep length is exactly 2**AW cycles.
- init_start asserted during CLEAR or on the init_done cycle: ignored while busy. On the init_done cycle the FSM is already IDLE, so a start there begins a new sweep next cycle.
- Collision, macro off:
  - If the winning read address equals the winning write address in the same cycle, the read is not granted.
  - The read pointer holds and the write proceeds; the read retries the next cycle.
- Reset mid-sweep: the FSM returns to IDLE asynchronously. Memory contents are unspecified; software must re-run init.
- All requests low: no enables, no state change other than the FSM.

Optional Feature:
- Macro INMF_ARB_FWD_EN.
- Defined:
  - A same-address read is granted alongside the write; port B is still enabled.
  - The write data is registered, and on the following cycle rd_rdata is the forwarded write data instead of doutb.
  - Read latency stays 1 and no stall is inserted.
- Undefined: stall behaviour as specified under Collision.

Decomposition:
- Package inmf_arb_pkg: FSM state enum (ST_IDLE, ST_CLEAR), default AW/DW localparams, INIT_VAL default.
- Sub-module inmf_rr_arb, parameterised N:
  - Inputs: req vector and an advance enable.
  - Outputs: one-hot grant and the registered pointer.
  - Instantiated once for writes and once for reads.

Test Plan:
- Single read: preload addr 0x10=0xDEADBEEF via wr requester 0; rd requester 2 reads 0x10 -> rd_ack[2] that cycle, rd_rvalid=4'b0100 and rd_rdata=0xDEADBEEF next cycle.
- Fairness: all 4 rd_req held high for 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle; rd_rvalid follows, delayed 1 cycle.
- Clear sweep: pulse init_start -> init_busy high for exactly 256 cycles, wr_req[0] unacked throughout, init_done pulses once; a read of 0xFF afterwards returns 0x00000000.
- Collision, macro off: wr 0x20=0x12345678 and rd 0x20 in the same cycle -> wr_ack now, rd_ack next cycle, rd_rdata=0x12345678. Macro on: both acked the same cycle, rd_rdata=0x12345678 next cycle.
- Reset mid-sweep: rst_n low at sweep cycle 100 -> all outputs at reset values immediately; after release, init_busy=0 and no init_done.
- Ignored start: second init_start at sweep cycle 50 -> still exactly one init_done, 256 cycles after the first start.

Source files
------------

// File: rtl/inmf_arb_pkg.sv
// Shared types and default sizes for the inmf_dram arbiter and its sub-blocks.
package inmf_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    localparam int          DEF_AW       = 8;
    localparam int          DEF_DW       = 32;
    localparam logic [31:0] DEF_INIT_VAL = 32'h0000_0000;

endpackage

// File: rtl/inmf_dram_arb_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer past the winner when advance is enabled.
module inmf_rr_arb #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;
    logic          found;

    // First pass covers indices at/after the pointer; the second pass is the
    // wrap-around and only matters when the first found nothing.
    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (PW'(i) >= ptr_q)) begin
                found    = 1'b1;
                gnt_idx  = PW'(i);
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                found    = 1'b1;
                gnt_idx  = PW'(i);
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && found) begin
            ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/inmf_dram_arb.sv
// Port arbiter and clear sequencer for one simple-dual-port inmf_dram.
// Define INMF_ARB_FWD_EN to forward same-address write data instead of stalling the read.
module inmf_dram_arb
    import inmf_arb_pkg::*;
#(
    parameter int          NW       = 2,
    parameter int          NR       = 4,
    parameter int          AW       = DEF_AW,
    parameter int          DW       = DEF_DW,
    parameter logic [DW-1:0] INIT_VAL = DW'(DEF_INIT_VAL)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init_start,
    output logic            init_busy,
    output logic            init_done,
    input  logic [NW-1:0]   wr_req,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NW*DW-1:0] wr_data,
    output logic [NW-1:0]   wr_ack,
    input  logic [NR-1:0]   rd_req,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR-1:0]   rd_ack,
    output logic [NR-1:0]   rd_rvalid,
    output logic [DW-1:0]   rd_rdata,
    output logic            ena,
    output logic            wea,
    output logic [AW-1:0]   addra,
    output logic [DW-1:0]   dina,
    output logic            enb,
    output logic [AW-1:0]   addrb,
    input  logic [DW-1:0]   doutb
);

    localparam int WPW = (NW > 1) ? $clog2(NW) : 1;
    localparam int RPW = (NR > 1) ? $clog2(NR) : 1;

    arb_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [NR-1:0] rvalid_q;

    logic [NW-1:0]  wr_gnt;
    logic [NR-1:0]  rd_gnt;
    logic [WPW-1:0] wr_ptr_unused;
    logic [RPW-1:0] rd_ptr_unused;
    logic [AW-1:0]  wr_sel_addr;
    logic [DW-1:0]  wr_sel_data;
    logic [AW-1:0]  rd_sel_addr;
    logic           idle;
    logic           wr_fire;
    logic           rd_fire;
    logic           collide;
    logic           rd_block;

    inmf_rr_arb #(.N(NW)) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (wr_req),
        .adv_i (idle),
        .gnt_o (wr_gnt),
        .ptr_o (wr_ptr_unused)
    );

    inmf_rr_arb #(.N(NR)) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (rd_req),
        .adv_i (idle && !rd_block),
        .gnt_o (rd_gnt),
        .ptr_o (rd_ptr_unused)
    );

    // Grants are one-hot, so an OR of masked lanes is the selected lane.
    always_comb begin
        wr_sel_addr = '0;
        wr_sel_data = '0;
        rd_sel_addr = '0;
        for (int i = 0; i < NW; i++) begin
            if (wr_gnt[i]) begin
                wr_sel_addr = wr_sel_addr | wr_addr[i*AW +: AW];
                wr_sel_data = wr_sel_data | wr_data[i*DW +: DW];
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (rd_gnt[i]) begin
                rd_sel_addr = rd_sel_addr | rd_addr[i*AW +: AW];
            end
        end
    end

    assign idle    = (state_q == ST_IDLE);
    assign wr_fire = idle && (|wr_gnt);
    assign collide = wr_fire && (|rd_gnt) && (rd_sel_addr == wr_sel_addr);
`ifdef INMF_ARB_FWD_EN
    assign rd_block = 1'b0;
`else
    assign rd_block = collide;
`endif
    assign rd_fire = idle && (|rd_gnt) && !rd_block;
    assign wr_ack  = wr_fire ? wr_gnt : '0;
    assign rd_ack  = rd_fire ? rd_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (init_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        init_busy = (state_q == ST_CLEAR);
        init_done = done_q;
        ena       = 1'b0;
        wea       = 1'b0;
        addra     = '0;
        dina      = '0;
        enb       = rd_fire;
        addrb     = rd_fire ? rd_sel_addr : '0;
        case (state_q)
            ST_CLEAR: begin
                ena   = 1'b1;
                wea   = 1'b1;
                addra = cnt_q;
                dina  = INIT_VAL;
            end
            default: begin
                if (wr_fire) begin
                    ena   = 1'b1;
                    wea   = 1'b1;
                    addra = wr_sel_addr;
                    dina  = wr_sel_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rd_ack;
        end
    end

    assign rd_rvalid = rvalid_q;

`ifdef INMF_ARB_FWD_EN
    logic          fwd_q;
    logic [DW-1:0] fwd_data_q;

    // The RAM read of a same-cycle same-address write is undefined, so the
    // returning data comes from the captured write instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= collide && rd_fire;
            fwd_data_q <= wr_sel_data;
        end
    end

    assign rd_rdata = fwd_q ? fwd_data_q : doutb;
`else
    assign rd_rdata = doutb;
`endif

endmodule
